// File: rtl/aha_clock_select_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package  : aha_clk_sel_pkg
// Brief    : Shared types and source codes for the clock-select controller/legs.
// Revision : 1.0
//------------------------------------------------------------------------------
package aha_clk_sel_pkg;

  localparam int c_SEL_W       = 3;
  localparam int c_NUM_SOURCES = 6;

  // Source codes agreed with the clock-switch legs
  localparam logic [c_SEL_W-1:0] c_SRC_XTAL  = 3'd0;
  localparam logic [c_SEL_W-1:0] c_SRC_PLL0  = 3'd1;
  localparam logic [c_SEL_W-1:0] c_SRC_PLL1  = 3'd2;
  localparam logic [c_SEL_W-1:0] c_SRC_RCOSC = 3'd3;
  localparam logic [c_SEL_W-1:0] c_SRC_EXT   = 3'd4;
  localparam logic [c_SEL_W-1:0] c_SRC_LPO   = 3'd5;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WAIT_OFF = 2'd2,
    ST_WAIT_ON  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/aha_clock_select_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Interface : aha_clock_select_ctrl_if
// Brief     : Request, leg handshake and status signals of the clock-select controller.
// Revision  : 1.0
//------------------------------------------------------------------------------
interface aha_clock_select_ctrl_if import aha_clk_sel_pkg::*; #(
  parameter int NUM_SOURCES = c_NUM_SOURCES,
  parameter int SEL_W       = c_SEL_W,
  parameter int TMO_W       = 8
);

  logic                   REQ_VALID;
  logic [SEL_W-1:0]       REQ_SEL;
  logic                   REQ_READY;
  logic [TMO_W-1:0]       TMO_LIMIT;
  logic                   ERR_CLR;
  logic [SEL_W-1:0]       SELECT_REQ;
  logic [NUM_SOURCES-1:0] SELECT_ACK;
  logic [SEL_W-1:0]       CUR_SEL;
  logic                   CUR_VALID;
  logic                   DONE;
  logic                   ERR_RANGE;
  logic                   ERR_TMO;

  modport master (
    output REQ_VALID, REQ_SEL, TMO_LIMIT, ERR_CLR, SELECT_ACK,
    input  REQ_READY, SELECT_REQ, CUR_SEL, CUR_VALID, DONE, ERR_RANGE, ERR_TMO
  );

  modport slave (
    input  REQ_VALID, REQ_SEL, TMO_LIMIT, ERR_CLR, SELECT_ACK,
    output REQ_READY, SELECT_REQ, CUR_SEL, CUR_VALID, DONE, ERR_RANGE, ERR_TMO
  );

endinterface
`default_nettype wire

// File: rtl/aha_clock_select_ctrl_sync.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : aha_sync_bit
// Brief    : SYNC_STAGES-deep async-reset synchronizer for one ACK bit.
// Revision : 1.0
//------------------------------------------------------------------------------
module aha_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic CLK,
  input  wire logic RESETn,
  input  wire logic i_d,
  output logic      o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/aha_clock_select_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : aha_clock_select_ctrl
// Brief    : Drives SELECT_REQ to the switch legs and tracks the off/on ACK handshake.
// Revision : 1.0
//------------------------------------------------------------------------------
module aha_clock_select_ctrl import aha_clk_sel_pkg::*; #(
  parameter int NUM_SOURCES = c_NUM_SOURCES,
  parameter int SEL_W       = c_SEL_W,
  parameter int RESET_SEL   = int'(c_SRC_XTAL),
  parameter int SYNC_STAGES = 2,
  parameter int TMO_W       = 8
) (
  input wire logic               CLK,
  input wire logic               RESETn,
  aha_clock_select_ctrl_if.slave bus
);

  localparam int                 c_CODES     = 2 ** SEL_W;
  localparam logic [SEL_W-1:0]   c_RESET_SEL = SEL_W'(RESET_SEL);
  localparam logic [SEL_W:0]     c_NUM_SRC   = (SEL_W + 1)'(NUM_SOURCES);

  logic [NUM_SOURCES-1:0] w_ack_s;
  logic [c_CODES-1:0]     w_ack_pad;

  for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_ack_sync
    aha_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .CLK    (CLK),
      .RESETn (RESETn),
      .i_d    (bus.SELECT_ACK[gi]),
      .o_q    (w_ack_s[gi])
    );
  end

  // Widened so any SEL_W-bit code indexes a defined bit
  assign w_ack_pad = c_CODES'(w_ack_s);

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel_req, w_sel_req_nxt;
  logic [SEL_W-1:0] r_cur_sel, w_cur_sel_nxt;
  logic [SEL_W-1:0] r_old_sel, w_old_sel_nxt;
  logic             r_cur_valid, w_cur_valid_nxt;
  logic             r_skip_off, w_skip_off_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err_range, r_err_tmo;
  logic [TMO_W-1:0] r_timer, w_timer_nxt;
  logic             w_set_range, w_set_tmo;
  logic             w_range_bad, w_same, w_tmo_hit;

  assign w_range_bad = ({1'b0, bus.REQ_SEL} >= c_NUM_SRC);
  assign w_same      = (bus.REQ_SEL == r_cur_sel) && r_cur_valid;
  assign w_tmo_hit   = (bus.TMO_LIMIT != '0) && (r_timer == bus.TMO_LIMIT);

  always_comb begin
    w_state_nxt     = r_state;
    w_sel_req_nxt   = r_sel_req;
    w_cur_sel_nxt   = r_cur_sel;
    w_old_sel_nxt   = r_old_sel;
    w_cur_valid_nxt = r_cur_valid;
    w_skip_off_nxt  = r_skip_off;
    w_done_nxt      = 1'b0;
    w_set_range     = 1'b0;
    w_set_tmo       = 1'b0;
    w_timer_nxt     = (r_timer == '1) ? r_timer : r_timer + TMO_W'(1);

    case (r_state)
      ST_INIT: begin
        if (w_ack_pad[c_RESET_SEL]) begin
          w_cur_valid_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_set_tmo       = 1'b1;
          w_cur_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        w_timer_nxt = r_timer;
        if (bus.REQ_VALID) begin
          if (w_range_bad) begin
            w_set_range = 1'b1;
          end else if (w_same) begin
            w_done_nxt = 1'b1;
          end else begin
            // With no confirmed source there is no outgoing ACK to wait for
            w_old_sel_nxt  = r_cur_sel;
            w_skip_off_nxt = !r_cur_valid;
            w_sel_req_nxt  = bus.REQ_SEL;
            w_timer_nxt    = '0;
            w_state_nxt    = ST_WAIT_OFF;
          end
        end
      end
      ST_WAIT_OFF: begin
        if (r_skip_off || !w_ack_pad[r_old_sel]) begin
          w_timer_nxt = '0;
          w_state_nxt = ST_WAIT_ON;
        end else if (w_tmo_hit) begin
          w_set_tmo       = 1'b1;
          w_cur_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      ST_WAIT_ON: begin
        if (w_ack_pad[r_sel_req]) begin
          w_cur_sel_nxt   = r_sel_req;
          w_cur_valid_nxt = 1'b1;
          w_done_nxt      = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_set_tmo       = 1'b1;
          w_cur_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state     <= ST_INIT;
      r_sel_req   <= c_RESET_SEL;
      r_cur_sel   <= c_RESET_SEL;
      r_old_sel   <= c_RESET_SEL;
      r_cur_valid <= 1'b0;
      r_skip_off  <= 1'b0;
      r_done      <= 1'b0;
      r_err_range <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_timer     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel_req   <= w_sel_req_nxt;
      r_cur_sel   <= w_cur_sel_nxt;
      r_old_sel   <= w_old_sel_nxt;
      r_cur_valid <= w_cur_valid_nxt;
      r_skip_off  <= w_skip_off_nxt;
      r_done      <= w_done_nxt;
      r_err_range <= w_set_range | (r_err_range & ~bus.ERR_CLR);
      r_err_tmo   <= w_set_tmo | (r_err_tmo & ~bus.ERR_CLR);
      r_timer     <= w_timer_nxt;
    end
  end

  assign bus.REQ_READY  = (r_state == ST_IDLE);
  assign bus.SELECT_REQ = r_sel_req;
  assign bus.CUR_SEL    = r_cur_sel;
  assign bus.CUR_VALID  = r_cur_valid;
  assign bus.DONE       = r_done;
  assign bus.ERR_RANGE  = r_err_range;
  assign bus.ERR_TMO    = r_err_tmo;

endmodule
`default_nettype wire

// File: tb/tb_aha_clock_select_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_aha_clock_select_ctrl
// Brief    : Randomised bench with leg model and DONE scoreboard for the controller.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_aha_clock_select_ctrl;
  import aha_clk_sel_pkg::*;

  localparam int S  = 2;
  localparam int NS = 6;
  localparam int SW = 3;
  localparam int TW = 8;

  logic CLK    = 1'b0;
  logic RESETn = 1'b0;

  aha_clock_select_ctrl_if #(.NUM_SOURCES(NS), .SEL_W(SW), .TMO_W(TW)) bus ();

  aha_clock_select_ctrl #(
    .NUM_SOURCES (NS),
    .SEL_W       (SW),
    .RESET_SEL   (0),
    .SYNC_STAGES (S),
    .TMO_W       (TW)
  ) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  // cyc at a negedge equals the number of the rising edge just taken
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int edge_no; int sel; } exp_t;
  exp_t sb_q[$];

  int n_vec  = 0;
  int n_fail = 0;
  int m_cur = 0, m_req = 0;
  bit m_valid = 0, m_err_range = 0, m_err_tmo = 0;

  function automatic void check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  always @(negedge CLK) begin : p_mon
    exp_t e;
    if (RESETn && bus.DONE) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", int'(bus.DONE), 0);
      end else begin
        e = sb_q.pop_front();
        check("done_cycle", cyc, e.edge_no);
        check("done_cur_sel", int'(bus.CUR_SEL), e.sel);
        check("done_cur_valid", int'(bus.CUR_VALID), 1);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic wait_noisy(input int target, input bit noise);
    while (cyc < target) begin
      bus.REQ_VALID = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.REQ_SEL   = 3'($urandom_range(0, 7));
      @(negedge CLK);
    end
    bus.REQ_VALID = 1'b0;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (bus.REQ_READY !== 1'b1 && guard < 300) begin
      @(negedge CLK);
      guard++;
    end
    if (bus.REQ_READY !== 1'b1) check("req_ready_wait", int'(bus.REQ_READY), 1);
  endtask

  task automatic accept(input int sel, output int e0);
    bus.REQ_VALID = 1'b1;
    bus.REQ_SEL   = 3'(sel);
    e0 = cyc + 1;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    bus.REQ_SEL   = 3'($urandom_range(0, 7));
  endtask

  // Legs: old drops d cycles after seeing the new code, new rises r cycles
  // after the controller can have observed the drop.
  task automatic do_switch(input int ns, input int d, input int r, input bit noise);
    int e0, off_exit, done_e, old;
    bit skip;
    wait_ready();
    old  = m_cur;
    skip = !m_valid;
    e0   = cyc + 1;
    if (ns == m_cur && m_valid) begin
      sb_q.push_back('{e0, ns});
      accept(ns, e0);
      check("same_select_req", int'(bus.SELECT_REQ), m_req);
      check("same_no_wait", int'(bus.REQ_READY), 1);
    end else begin
      off_exit = skip ? e0 + 1 : e0 + d + S + 1;
      done_e   = off_exit + r + 1 + S;
      sb_q.push_back('{done_e, ns});
      accept(ns, e0);
      m_req = ns;
      check("sw_select_req", int'(bus.SELECT_REQ), ns);
      check("sw_busy", int'(bus.REQ_READY), 0);
      if (!skip) begin
        wait_noisy(e0 + d, noise);
        bus.SELECT_ACK[old] = 1'b0;
      end
      wait_noisy(off_exit + r, noise);
      bus.SELECT_ACK[ns] = 1'b1;
      wait_cyc(done_e);
      m_cur   = ns;
      m_valid = 1'b1;
      check("sw_cur_sel", int'(bus.CUR_SEL), m_cur);
      check("sw_ready_after", int'(bus.REQ_READY), 1);
    end
    check("err_range_hold", int'(bus.ERR_RANGE), int'(m_err_range));
  endtask

  task automatic do_timeout(input int ns, input int lim);
    int e0, tmo_e, old;
    bus.TMO_LIMIT = 8'(lim);
    wait_ready();
    old = m_cur;
    accept(ns, e0);
    m_req = ns;
    bus.SELECT_ACK[old] = 1'b0;
    tmo_e = (e0 + S + 1) + lim + 1;
    wait_cyc(tmo_e - 1);
    check("tmo_not_early", int'(bus.ERR_TMO), 0);
    wait_cyc(tmo_e);
    m_valid   = 1'b0;
    m_err_tmo = 1'b1;
    check("tmo_set", int'(bus.ERR_TMO), 1);
    check("tmo_cur_valid", int'(bus.CUR_VALID), 0);
    check("tmo_ready", int'(bus.REQ_READY), 1);
    check("tmo_select_req", int'(bus.SELECT_REQ), ns);
    check("tmo_cur_sel", int'(bus.CUR_SEL), old);
    bus.TMO_LIMIT = '0;
  endtask

  task automatic do_range(input int bad, input bit clr_same);
    int e0;
    wait_ready();
    bus.ERR_CLR = clr_same;
    accept(bad, e0);
    bus.ERR_CLR = 1'b0;
    m_err_range = 1'b1;
    if (clr_same) m_err_tmo = 1'b0;
    check("range_set", int'(bus.ERR_RANGE), 1);
    check("range_tmo_flag", int'(bus.ERR_TMO), int'(m_err_tmo));
    check("range_select_req", int'(bus.SELECT_REQ), m_req);
    check("range_cur_sel", int'(bus.CUR_SEL), m_cur);
    check("range_ready", int'(bus.REQ_READY), 1);
    @(negedge CLK);
    check("range_sticky", int'(bus.ERR_RANGE), 1);
  endtask

  task automatic do_clear();
    bus.ERR_CLR = 1'b1;
    @(negedge CLK);
    bus.ERR_CLR = 1'b0;
    m_err_range = 1'b0;
    m_err_tmo   = 1'b0;
    check("clr_range", int'(bus.ERR_RANGE), 0);
    check("clr_tmo", int'(bus.ERR_TMO), 0);
  endtask

  // Releases reset at a negedge; leg RESET_SEL acks ack_dly cycles later
  task automatic release_and_init(input int ack_dly);
    int rel, v_e;
    @(negedge CLK);
    RESETn = 1'b1;
    rel = cyc;
    wait_cyc(rel + ack_dly);
    bus.SELECT_ACK[int'(c_SRC_XTAL)] = 1'b1;
    v_e = rel + ack_dly + 1 + S;
    wait_cyc(v_e - 1);
    check("init_not_early", int'(bus.CUR_VALID), 0);
    check("init_busy", int'(bus.REQ_READY), 0);
    wait_cyc(v_e);
    check("init_cur_valid", int'(bus.CUR_VALID), 1);
    check("init_ready", int'(bus.REQ_READY), 1);
    check("init_select_req", int'(bus.SELECT_REQ), 0);
    m_cur = 0; m_req = 0; m_valid = 1'b1; m_err_range = 1'b0; m_err_tmo = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_select_req"}, int'(bus.SELECT_REQ), 0);
    check({tag, "_cur_sel"}, int'(bus.CUR_SEL), 0);
    check({tag, "_cur_valid"}, int'(bus.CUR_VALID), 0);
    check({tag, "_ready"}, int'(bus.REQ_READY), 0);
    check({tag, "_done"}, int'(bus.DONE), 0);
    check({tag, "_errs"}, int'({bus.ERR_RANGE, bus.ERR_TMO}), 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int e0, op, ns;
    bus.REQ_VALID  = 1'b0;
    bus.REQ_SEL    = '0;
    bus.TMO_LIMIT  = '0;
    bus.ERR_CLR    = 1'b0;
    bus.SELECT_ACK = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    release_and_init(3);

    do_switch(2, 4, 5, 1'b0);
    do_range(7, 1'b0);
    do_clear();
    do_timeout(1, 10);
    do_switch(2, 0, 2, 1'b0);
    do_switch(2, 0, 0, 1'b0);
    do_range(6, 1'b1);
    do_clear();

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 9));
      if (op < 6) begin
        bus.TMO_LIMIT = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(100, 255));
        do_switch(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        bus.TMO_LIMIT = '0;
      end else if (op < 8) begin
        do_range(int'($urandom_range(NS, 7)), 1'($urandom_range(0, 1)));
      end else if (op == 8 && m_valid) begin
        ns = (m_cur + 1 + int'($urandom_range(0, NS - 2))) % NS;
        do_timeout(ns, int'($urandom_range(3, 20)));
      end else begin
        do_clear();
      end
    end

    // Reset in the middle of a 0 -> 4 switch
    do_switch(0, 1, 1, 1'b0);
    wait_ready();
    accept(4, e0);
    bus.SELECT_ACK[0] = 1'b0;
    wait_cyc(e0 + S + 3);
    #2 RESETn = 1'b0;
    #1 check_reset_outputs("midrst");
    bus.SELECT_ACK = '0;
    @(negedge CLK);
    release_and_init(2);
    do_switch(3, 1, 2, 1'b1);

    repeat (5) @(negedge CLK);
    check("scoreboard_empty", sb_q.size(), 0);
    check("final_err_range", int'(bus.ERR_RANGE), int'(m_err_range));
    check("final_err_tmo", int'(bus.ERR_TMO), int'(m_err_tmo));
    check("final_cur_sel", int'(bus.CUR_SEL), m_cur);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
